// File: rtl/pll_lock_detector.sv
// -----------------------------------------------------------------------------
// pll_lock_detector
//
// Watches the digital PLL's reference clock and phase-error flag, measures
// every reference period in system-clock cycles together with the number of
// out-of-phase cycles inside it, and drives a hysteretic lock FSM
// (UNLOCKED -> ACQUIRING -> LOCKED <-> HOLD). A missing reference is flagged
// after TIMEOUT system cycles without a rising edge.
//
// Ports:
//   i_sys_clk      system clock
//   i_rst          synchronous, active-high reset
//   i_ref_clk      reference square wave (asynchronous)
//   i_phase_error  PLL out-of-phase flag (asynchronous), 1 = mismatch
//   i_err_thresh   max error cycles per period still counted as good
//   i_min_period   min acceptable period; shorter periods are bad
//   o_locked       1 in LOCKED and HOLD
//   o_state        0 UNLOCKED, 1 ACQUIRING, 2 LOCKED, 3 HOLD
//   o_period       last measured period in system cycles
//   o_err_count    error cycles counted in the last period
//   o_meas_valid   one-cycle pulse when o_period/o_err_count update
//   o_lock_lost    one-cycle pulse on leaving lock
//   o_ref_lost     reference timeout flag
// -----------------------------------------------------------------------------
module pll_lock_detector #(
    parameter int PERIOD_W     = 16,
    parameter int ERR_W        = 16,
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 4,
    parameter int TIMEOUT      = 4096
) (
    input  logic                i_sys_clk,
    input  logic                i_rst,
    input  logic                i_ref_clk,
    input  logic                i_phase_error,
    input  logic [ERR_W-1:0]    i_err_thresh,
    input  logic [PERIOD_W-1:0] i_min_period,
    output logic                o_locked,
    output logic [1:0]          o_state,
    output logic [PERIOD_W-1:0] o_period,
    output logic [ERR_W-1:0]    o_err_count,
    output logic                o_meas_valid,
    output logic                o_lock_lost,
    output logic                o_ref_lost
);

    localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]    LOCK_CNT_C     = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]    UNLOCK_CNT_C   = CNT_W'(UNLOCK_COUNT);
    localparam logic [PERIOD_W-1:0] PER_MAX_C      = {PERIOD_W{1'b1}};
    localparam logic [ERR_W-1:0]    ERR_MAX_C      = {ERR_W{1'b1}};
    localparam logic [PERIOD_W-1:0] TIMEOUT_LAST_C = PERIOD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED  = 2'd0,
        ST_ACQUIRING = 2'd1,
        ST_LOCKED    = 2'd2,
        ST_HOLD      = 2'd3
    } state_t;

    // Synchronizers (ref and error share identical depth so they stay aligned)
    logic ref_meta_r, ref_sync_r, ref_prev_r;
    logic err_meta_r, err_sync_r;

    // Measurement datapath
    logic [PERIOD_W-1:0] per_cnt_r;
    logic [ERR_W-1:0]    err_cnt_r;
    logic [PERIOD_W-1:0] period_r;
    logic [ERR_W-1:0]    err_count_r;
    logic                meas_valid_r;
    logic                primed_r;
    logic                ref_lost_r;

    logic                edge_s;
    logic                timeout_s;
    logic                good_s;
    logic [PERIOD_W-1:0] per_inc_s;
    logic [ERR_W-1:0]    err_inc_s;

    // Lock FSM
    state_t           state_r, state_nx_s;
    logic [CNT_W-1:0] good_cnt_r, good_cnt_nx_s;
    logic [CNT_W-1:0] bad_cnt_r, bad_cnt_nx_s;
    logic             locked_r;
    logic             lock_lost_r, lock_lost_nx_s;

    assign edge_s = ref_sync_r & ~ref_prev_r;

    // A coincident edge always wins over the timeout; only one timeout per loss.
    assign timeout_s = ~edge_s & ~ref_lost_r & (per_cnt_r == TIMEOUT_LAST_C);

    assign per_inc_s = (per_cnt_r == PER_MAX_C) ? per_cnt_r : per_cnt_r + PERIOD_W'(1);
    assign err_inc_s = ((err_cnt_r == ERR_MAX_C) || !err_sync_r) ? err_cnt_r
                                                                  : err_cnt_r + ERR_W'(1);

    assign good_s = (err_count_r <= i_err_thresh) && (period_r >= i_min_period);

    // Two-flop synchronizers plus the previous-ref flop for edge detection
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            ref_meta_r <= 1'b0;
            ref_sync_r <= 1'b0;
            ref_prev_r <= 1'b0;
            err_meta_r <= 1'b0;
            err_sync_r <= 1'b0;
        end else begin
            ref_meta_r <= i_ref_clk;
            ref_sync_r <= ref_meta_r;
            ref_prev_r <= ref_sync_r;
            err_meta_r <= i_phase_error;
            err_sync_r <= err_meta_r;
        end
    end

    // Period/error counters, measurement capture, priming and timeout flag
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            per_cnt_r    <= {PERIOD_W{1'b0}};
            err_cnt_r    <= {ERR_W{1'b0}};
            period_r     <= {PERIOD_W{1'b0}};
            err_count_r  <= {ERR_W{1'b0}};
            meas_valid_r <= 1'b0;
            primed_r     <= 1'b0;
            ref_lost_r   <= 1'b0;
        end else if (edge_s) begin
            // The edge cycle belongs to the new window, so its error sample seeds err_cnt.
            per_cnt_r  <= {PERIOD_W{1'b0}};
            err_cnt_r  <= ERR_W'(err_sync_r);
            primed_r   <= 1'b1;
            ref_lost_r <= 1'b0;
            if (primed_r) begin
                period_r     <= per_inc_s;
                err_count_r  <= err_cnt_r;
                meas_valid_r <= 1'b1;
            end else begin
                meas_valid_r <= 1'b0;
            end
        end else if (timeout_s) begin
            // Counters freeze here until the next edge re-primes the window.
            ref_lost_r   <= 1'b1;
            primed_r     <= 1'b0;
            meas_valid_r <= 1'b0;
        end else if (ref_lost_r) begin
            meas_valid_r <= 1'b0;
        end else begin
            per_cnt_r    <= per_inc_s;
            err_cnt_r    <= err_inc_s;
            meas_valid_r <= 1'b0;
        end
    end

    // Lock FSM next-state; evaluated only on measurement pulses or a timeout
    always_comb begin
        state_nx_s     = state_r;
        good_cnt_nx_s  = good_cnt_r;
        bad_cnt_nx_s   = bad_cnt_r;
        lock_lost_nx_s = 1'b0;
        if (timeout_s) begin
            state_nx_s     = ST_UNLOCKED;
            good_cnt_nx_s  = {CNT_W{1'b0}};
            bad_cnt_nx_s   = {CNT_W{1'b0}};
            lock_lost_nx_s = (state_r == ST_LOCKED) || (state_r == ST_HOLD);
        end else if (meas_valid_r) begin
            case (state_r)
                ST_UNLOCKED: begin
                    if (!good_s) begin
                        state_nx_s = ST_UNLOCKED;
                    end else if (CNT_W'(1) >= LOCK_CNT_C) begin
                        state_nx_s    = ST_LOCKED;
                        good_cnt_nx_s = {CNT_W{1'b0}};
                    end else begin
                        state_nx_s    = ST_ACQUIRING;
                        good_cnt_nx_s = CNT_W'(1);
                    end
                end
                ST_ACQUIRING: begin
                    if (!good_s) begin
                        state_nx_s    = ST_UNLOCKED;
                        good_cnt_nx_s = {CNT_W{1'b0}};
                    end else if ((good_cnt_r + CNT_W'(1)) >= LOCK_CNT_C) begin
                        state_nx_s    = ST_LOCKED;
                        good_cnt_nx_s = {CNT_W{1'b0}};
                    end else begin
                        good_cnt_nx_s = good_cnt_r + CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (good_s) begin
                        state_nx_s = ST_LOCKED;
                    end else if (CNT_W'(1) >= UNLOCK_CNT_C) begin
                        state_nx_s     = ST_UNLOCKED;
                        lock_lost_nx_s = 1'b1;
                    end else begin
                        state_nx_s   = ST_HOLD;
                        bad_cnt_nx_s = CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (good_s) begin
                        state_nx_s   = ST_LOCKED;
                        bad_cnt_nx_s = {CNT_W{1'b0}};
                    end else if ((bad_cnt_r + CNT_W'(1)) >= UNLOCK_CNT_C) begin
                        state_nx_s     = ST_UNLOCKED;
                        bad_cnt_nx_s   = {CNT_W{1'b0}};
                        lock_lost_nx_s = 1'b1;
                    end else begin
                        bad_cnt_nx_s = bad_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx_s    = ST_UNLOCKED;
                    good_cnt_nx_s = {CNT_W{1'b0}};
                    bad_cnt_nx_s  = {CNT_W{1'b0}};
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Lock FSM state register with registered lock and loss indications
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state_r     <= ST_UNLOCKED;
            good_cnt_r  <= {CNT_W{1'b0}};
            bad_cnt_r   <= {CNT_W{1'b0}};
            locked_r    <= 1'b0;
            lock_lost_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            good_cnt_r  <= good_cnt_nx_s;
            bad_cnt_r   <= bad_cnt_nx_s;
            locked_r    <= (state_nx_s == ST_LOCKED) || (state_nx_s == ST_HOLD);
            lock_lost_r <= lock_lost_nx_s;
        end
    end

    assign o_locked     = locked_r;
    assign o_state      = state_r;
    assign o_period     = period_r;
    assign o_err_count  = err_count_r;
    assign o_meas_valid = meas_valid_r;
    assign o_lock_lost  = lock_lost_r;
    assign o_ref_lost   = ref_lost_r;

endmodule

// File: tb/tb_pll_lock_detector.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_detector
//
// Drives the reference and phase-error inputs one system cycle at a time and
// compares every output after every clock against a behavioural model built
// from rising-edge timestamps, per-window error sums and good/bad streaks.
// -----------------------------------------------------------------------------
module tb_pll_lock_detector;

    localparam int PW  = 16;
    localparam int EW  = 16;
    localparam int LC  = 8;
    localparam int UC  = 4;
    localparam int TMO = 100;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          ref_clk;
    logic          phase_error;
    logic [EW-1:0] err_thresh;
    logic [PW-1:0] min_period;
    logic          o_locked;
    logic [1:0]    o_state;
    logic [PW-1:0] o_period;
    logic [EW-1:0] o_err_count;
    logic          o_meas_valid;
    logic          o_lock_lost;
    logic          o_ref_lost;

    always #5 sys_clk = ~sys_clk;

    pll_lock_detector #(
        .PERIOD_W    (PW),
        .ERR_W       (EW),
        .LOCK_COUNT  (LC),
        .UNLOCK_COUNT(UC),
        .TIMEOUT     (TMO)
    ) dut (
        .i_sys_clk    (sys_clk),
        .i_rst        (rst),
        .i_ref_clk    (ref_clk),
        .i_phase_error(phase_error),
        .i_err_thresh (err_thresh),
        .i_min_period (min_period),
        .o_locked     (o_locked),
        .o_state      (o_state),
        .o_period     (o_period),
        .o_err_count  (o_err_count),
        .o_meas_valid (o_meas_valid),
        .o_lock_lost  (o_lock_lost),
        .o_ref_lost   (o_ref_lost)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: input history, window bookkeeping and streak-based lock view.
    logic mh1, mh2, mh3, eh1, eh2;
    bit   m_primed, m_lost, m_valid, m_locked, m_lost_pulse;
    int   m_cyc = 0;
    int   m_last_cap, m_win_err, m_period, m_err, m_run;

    // Observed-event bookkeeping for scenario checks
    int n_valid = 0, n_lost = 0, last_valid_cyc = 0, rl_cyc = 0, lock_valids = -1;
    bit prev_rl = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, m_cyc, obs, exp);
    endtask

    task automatic model_reset();
        mh1 = 1'b0; mh2 = 1'b0; mh3 = 1'b0; eh1 = 1'b0; eh2 = 1'b0;
        m_primed = 1'b0; m_lost = 1'b0; m_valid = 1'b0; m_locked = 1'b0; m_lost_pulse = 1'b0;
        m_last_cap = m_cyc; m_win_err = 0; m_period = 0; m_err = 0; m_run = 0;
    endtask

    function automatic int exp_state();
        if (m_locked) return (m_run != 0) ? 3 : 2;
        else          return (m_run != 0) ? 1 : 0;
    endfunction

    // One model step per posedge, using the inputs the DUT just sampled.
    task automatic model_step();
        logic rise_d, err_d, tmo, g;
        m_cyc++;
        if (rst) begin
            model_reset();
        end else begin
            rise_d = mh2 & ~mh3;
            err_d  = eh2;
            tmo    = !rise_d && !m_lost && ((m_cyc - m_last_cap) == TMO);
            m_lost_pulse = 1'b0;
            if (tmo) begin
                if (m_locked) m_lost_pulse = 1'b1;
                m_locked = 1'b0;
                m_run    = 0;
            end else if (m_valid) begin
                g = (m_err <= int'(err_thresh)) && (m_period >= int'(min_period));
                if (g) begin
                    if (!m_locked) begin
                        m_run++;
                        if (m_run >= LC) begin m_locked = 1'b1; m_run = 0; end
                    end else begin
                        m_run = 0;
                    end
                end else begin
                    if (!m_locked) begin
                        m_run = 0;
                    end else begin
                        m_run++;
                        if (m_run >= UC) begin m_locked = 1'b0; m_run = 0; m_lost_pulse = 1'b1; end
                    end
                end
            end
            m_valid = 1'b0;
            if (rise_d) begin
                if (m_primed) begin
                    m_valid  = 1'b1;
                    m_period = m_cyc - m_last_cap;
                    m_err    = m_win_err;
                end
                m_primed   = 1'b1;
                m_lost     = 1'b0;
                m_last_cap = m_cyc;
                m_win_err  = int'(err_d);
            end else if (tmo) begin
                m_lost   = 1'b1;
                m_primed = 1'b0;
            end else if (!m_lost) begin
                m_win_err += int'(err_d);
            end
            mh3 = mh2; mh2 = mh1; mh1 = ref_clk;
            eh2 = eh1; eh1 = phase_error;
        end
    endtask

    task automatic compare_all();
        check_eq("state",      32'(o_state),      32'(exp_state()));
        check_eq("locked",     32'(o_locked),     32'(m_locked));
        check_eq("meas_valid", 32'(o_meas_valid), 32'(m_valid));
        check_eq("lock_lost",  32'(o_lock_lost),  32'(m_lost_pulse));
        check_eq("ref_lost",   32'(o_ref_lost),   32'(m_lost));
        check_eq("period",     32'(o_period),     32'(m_period));
        check_eq("err_count",  32'(o_err_count),  32'(m_err));
        if (o_meas_valid) begin n_valid++; last_valid_cyc = m_cyc; end
        if (o_lock_lost) n_lost++;
        if (o_ref_lost && !prev_rl) rl_cyc = m_cyc;
        prev_rl = o_ref_lost;
        if (o_locked && lock_valids < 0) lock_valids = n_valid;
    endtask

    task automatic tick(input logic r, input logic e);
        ref_clk     = r;
        phase_error = e;
        @(posedge sys_clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic send_period(input int len, input int high, input int nerr, input int off);
        for (int i = 0; i < len; i++) tick(i < high, (i >= off) && (i < off + nerr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    initial begin
        int lat, v0, l0, len, hi, r;
        bit got;
        logic [PW-1:0] first_per;
        logic [EW-1:0] first_err;

        rst = 1'b1; ref_clk = 1'b0; phase_error = 1'b0;
        err_thresh = 16'd2; min_period = 16'd4;
        idle(2);
        rst = 1'b0;
        check_eq("reset_state", 32'(o_state), 32'd0);

        // Lock acquisition at 20-cycle period; second rise checks latency.
        send_period(20, 10, 0, 0);
        got = 1'b0; lat = 0; first_per = '0; first_err = '0;
        for (int i = 0; i < 20; i++) begin
            tick(i < 10, 1'b0);
            if (!got && o_meas_valid) begin
                got = 1'b1; lat = i + 1; first_per = o_period; first_err = o_err_count;
            end
        end
        check_eq("latency", 32'(lat), 32'd3);
        check_eq("first_period", 32'(first_per), 32'd20);
        check_eq("first_err", 32'(first_err), 32'd0);
        for (int k = 0; k < 7; k++) send_period(20, 10, 0, 0);
        check_eq("valids_to_lock", 32'(lock_valids), 32'd8);
        check_eq("locked_after_acq", 32'(o_state), 32'd2);

        // Four bad periods, then one good period to capture the fourth.
        l0 = n_lost;
        for (int k = 0; k < 4; k++) send_period(20, 10, 3, 5);
        send_period(20, 10, 0, 0);
        check_eq("unlock_pulses", 32'(n_lost - l0), 32'd1);
        check_eq("unlock_state", 32'(o_state), 32'd0);

        // Relock, then 3 bad / 1 good / 3 bad / 1 good must not drop lock.
        for (int k = 0; k < 10; k++) send_period(20, 10, 0, 0);
        l0 = n_lost;
        for (int k = 0; k < 3; k++) send_period(20, 10, 3, 2);
        send_period(20, 10, 0, 0);
        for (int k = 0; k < 3; k++) send_period(20, 10, 3, 2);
        send_period(20, 10, 0, 0);
        send_period(20, 10, 0, 0);
        check_eq("hold_no_loss", 32'(n_lost - l0), 32'd0);
        check_eq("hold_relocked", 32'(o_state), 32'd2);

        // Reference stops while locked.
        l0 = n_lost;
        idle(TMO + 10);
        check_eq("tmo_gap", 32'(rl_cyc - last_valid_cyc), 32'(TMO));
        check_eq("tmo_pulses", 32'(n_lost - l0), 32'd1);
        check_eq("tmo_state", 32'(o_state), 32'd0);
        v0 = n_valid;
        send_period(20, 10, 0, 0);
        send_period(20, 10, 0, 0);
        check_eq("restart_valids", 32'(n_valid - v0), 32'd1);
        check_eq("restart_period", 32'(o_period), 32'd20);
        check_eq("restart_acq", 32'(o_state), 32'd1);

        // Glitch pulse while acquiring.
        send_period(20, 10, 0, 0);
        send_period(2, 1, 0, 0);
        send_period(20, 10, 0, 0);
        check_eq("glitch_state", 32'(o_state), 32'd0);

        // Reach HOLD, then reset.
        for (int k = 0; k < 9; k++) send_period(20, 10, 0, 0);
        send_period(20, 10, 3, 4);
        for (int i = 0; i < 5; i++) tick(i < 10, 1'b0);
        check_eq("pre_rst_hold", 32'(o_state), 32'd3);
        rst = 1'b1;
        tick(1'b1, 1'b0);
        rst = 1'b0;
        check_eq("rst_state", 32'(o_state), 32'd0);
        check_eq("rst_lock_lost", 32'(o_lock_lost), 32'd0);
        idle(3);

        // Period exactly TIMEOUT (edge wins) and TIMEOUT+1 (timeout fires).
        send_period(20, 10, 0, 0);
        send_period(TMO, 10, 0, 0);
        send_period(TMO + 1, 10, 0, 0);
        send_period(20, 10, 0, 0);
        send_period(20, 10, 0, 0);

        // Randomized periods, thresholds, error bursts, dropouts and resets.
        for (int k = 0; k < 200; k++) begin
            err_thresh = 16'($urandom_range(0, 4));
            min_period = 16'($urandom_range(2, 10));
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                idle(TMO + int'($urandom_range(0, 5)));
            end else if (r < 5) begin
                rst = 1'b1;
                tick(1'($urandom_range(0, 1)), 1'b0);
                rst = 1'b0;
            end else begin
                len = int'($urandom_range(2, 40));
                hi  = int'($urandom_range(1, len - 1));
                send_period(len, hi, int'($urandom_range(0, 4)), int'($urandom_range(0, len - 1)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
